// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder slice:
// FSM state encoding and the memory-mapped I/O address.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/mem_array.sv
// Single-port 2^AW x 16 RAM: synchronous write, combinational read of the
// addressed word so the responder can register it at the completion edge.
module mem_array #(
  parameter int AW = 8
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   din,
  output logic [15:0]   dout
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder with a four-phase REQ/R handshake, a RAM
// window aliased over the low AW address bits and one I/O word at IO_ADDR.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        REQ_RD,
  input  logic        REQ_WR,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  input  logic [15:0] SW,
  output logic [15:0] RDATA,
  output logic        R,
  output logic [15:0] HEX
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Handshake: a request is a level on REQ_RD/REQ_WR sampled in IDLE. R is
  // raised when the access completes and dropped only after both request
  // lines are seen low, so valid and ready never overlap across transactions.
  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] cap_addr;
  logic [15:0] cap_wdata;
  logic        cap_wr;

  logic        is_io;
  logic        complete;
  logic        ram_we;
  logic [15:0] ram_dout;

  assign is_io    = (cap_addr == IO_ADDR);
  assign complete = (state == BUSY) && (cnt == 4'd0);
  // Reset must win over a completing write, so it gates the RAM enable.
  assign ram_we   = complete && cap_wr && !is_io && !Reset;

  mem_array #(.AW(AW)) u_mem_array (
    .Clk  (Clk),
    .we   (ram_we),
    .addr (cap_addr[AW-1:0]),
    .din  (cap_wdata),
    .dout (ram_dout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      R         <= 1'b0;
      RDATA     <= 16'h0000;
      HEX       <= 16'h0000;
      cap_addr  <= 16'h0000;
      cap_wdata <= 16'h0000;
      cap_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_RD || REQ_WR) begin
            cap_addr  <= ADDR;
            cap_wdata <= WDATA;
            cap_wr    <= REQ_WR;
            cnt       <= WAIT_INIT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (cap_wr) begin
              if (is_io) begin
                HEX <= cap_wdata;
              end
            end else begin
              RDATA <= is_io ? SW : ram_dout;
            end
            R     <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!REQ_RD && !REQ_WR) begin
            R     <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          R     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
